// File: rtl/tag_cmd_sequencer.sv
// rtl/tag_cmd_sequencer.sv - control FSM that validates, dispatches and re-arms tag command packets
module tag_cmd_sequencer #(
    parameter int unsigned REARM_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [11:0] NOREPLY_MASK = 12'h030
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] cmd_in,
    input  logic        packet_complete,
    input  logic        crc5invalid,
    input  logic        crc16invalid,
    input  logic        handler_done,
    input  logic        tx_done,
    output logic        parser_reset,
    output logic        handler_start,
    output logic [3:0]  handler_sel,
    output logic        tx_go,
    output logic        busy,
    output logic        err_crc,
    output logic        err_timeout,
    output logic [7:0]  drop_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DISPATCH,
        S_WAIT_HANDLER,
        S_WAIT_TX,
        S_REARM
    } state_t;

    localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);
    localparam logic [7:0] REARM_LAST = 8'(REARM_CYCLES - 1);

    state_t     state;
    logic [7:0] wd_cnt;
    logic [7:0] rearm_cnt;
    logic       noreply;
    logic [3:0] sel_idx;
    logic       sel_noreply;
    logic       bad_packet;
    logic [7:0] drop_inc;

    // Multi-hot commands resolve to the lowest set bit.
    function automatic logic [3:0] lowest_index(input logic [11:0] v);
        lowest_index = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (v[i]) lowest_index = 4'(i);
        end
    endfunction

    assign sel_idx     = lowest_index(cmd_in);
    assign sel_noreply = |((12'd1 << sel_idx) & NOREPLY_MASK);
    assign bad_packet  = crc5invalid || crc16invalid || (cmd_in == 12'd0);
    assign drop_inc    = (drop_count == 8'hFF) ? drop_count : drop_count + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_REARM;
            parser_reset  <= 1'b1;
            rearm_cnt     <= 8'd0;
            wd_cnt        <= 8'd0;
            noreply       <= 1'b0;
            handler_start <= 1'b0;
            handler_sel   <= 4'd0;
            tx_go         <= 1'b0;
            busy          <= 1'b0;
            err_crc       <= 1'b0;
            err_timeout   <= 1'b0;
            drop_count    <= 8'd0;
        end else begin
            handler_start <= 1'b0;
            err_crc       <= 1'b0;
            err_timeout   <= 1'b0;
            case (state)
                S_IDLE: begin
                    parser_reset <= 1'b0;
                    if (packet_complete) begin
                        state <= S_CHECK;
                        busy  <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (bad_packet) begin
                        err_crc      <= 1'b1;
                        drop_count   <= drop_inc;
                        state        <= S_REARM;
                        parser_reset <= 1'b1;
                        rearm_cnt    <= 8'd0;
                    end else begin
                        handler_sel   <= sel_idx;
                        noreply       <= sel_noreply;
                        handler_start <= 1'b1;
                        state         <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    wd_cnt <= 8'd0;
                    state  <= S_WAIT_HANDLER;
                end
                S_WAIT_HANDLER: begin
                    // Completion is checked before the watchdog so done wins a tie.
                    if (handler_done) begin
                        if (noreply) begin
                            state        <= S_REARM;
                            parser_reset <= 1'b1;
                            rearm_cnt    <= 8'd0;
                        end else begin
                            state  <= S_WAIT_TX;
                            tx_go  <= 1'b1;
                            wd_cnt <= 8'd0;
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        err_timeout  <= 1'b1;
                        drop_count   <= drop_inc;
                        state        <= S_REARM;
                        parser_reset <= 1'b1;
                        rearm_cnt    <= 8'd0;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                S_WAIT_TX: begin
                    if (tx_done) begin
                        tx_go        <= 1'b0;
                        state        <= S_REARM;
                        parser_reset <= 1'b1;
                        rearm_cnt    <= 8'd0;
                    end else if (wd_cnt == WD_LAST) begin
                        tx_go        <= 1'b0;
                        err_timeout  <= 1'b1;
                        drop_count   <= drop_inc;
                        state        <= S_REARM;
                        parser_reset <= 1'b1;
                        rearm_cnt    <= 8'd0;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                S_REARM: begin
                    if (rearm_cnt == REARM_LAST) begin
                        state        <= S_IDLE;
                        parser_reset <= 1'b0;
                        busy         <= 1'b0;
                    end else begin
                        rearm_cnt <= rearm_cnt + 8'd1;
                    end
                end
                default: begin
                    state        <= S_REARM;
                    parser_reset <= 1'b1;
                    rearm_cnt    <= 8'd0;
                    tx_go        <= 1'b0;
                    busy         <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tag_cmd_sequencer.sv
// tb/tb_tag_cmd_sequencer.sv - randomized packet-level bench for tag_cmd_sequencer
module tb_tag_cmd_sequencer;

    localparam int REARM_CYCLES = 2;
    localparam int TIMEOUT      = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] cmd_in;
    logic        packet_complete;
    logic        crc5invalid;
    logic        crc16invalid;
    logic        handler_done;
    logic        tx_done;
    logic        parser_reset;
    logic        handler_start;
    logic [3:0]  handler_sel;
    logic        tx_go;
    logic        busy;
    logic        err_crc;
    logic        err_timeout;
    logic [7:0]  drop_count;

    int          n_checks = 0;
    int          n_errors = 0;
    int          model_drops = 0;
    int          model_sel = 0;
    logic [11:0] noreply_mask = 12'h030;

    tag_cmd_sequencer #(
        .REARM_CYCLES(REARM_CYCLES),
        .TIMEOUT     (TIMEOUT),
        .NOREPLY_MASK(12'h030)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_in         (cmd_in),
        .packet_complete(packet_complete),
        .crc5invalid    (crc5invalid),
        .crc16invalid   (crc16invalid),
        .handler_done   (handler_done),
        .tx_done        (tx_done),
        .parser_reset   (parser_reset),
        .handler_start  (handler_start),
        .handler_sel    (handler_sel),
        .tx_go          (tx_go),
        .busy           (busy),
        .err_crc        (err_crc),
        .err_timeout    (err_timeout),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Index of the lowest set bit: isolate it arithmetically, then take its log2.
    function automatic int exp_sel(input logic [11:0] cmd);
        logic [11:0] low;
        low = cmd & (~cmd + 12'd1);
        return $clog2(low);
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Entered at the first negedge of REARM; ends at the first IDLE negedge.
    task automatic finish_rearm();
        check_eq("rearm_first", parser_reset, 1);
        check_eq("rearm_drops", drop_count, model_drops);
        packet_complete = 1'b0;
        cmd_in          = 12'($urandom);
        for (int i = 1; i < REARM_CYCLES; i++) begin
            handler_done = 1'($urandom);
            @(negedge clk);
            handler_done = 1'b0;
            check_eq("rearm_hold", parser_reset, 1);
            check_eq("rearm_no_crc_pulse", err_crc, 0);
            check_eq("rearm_no_to_pulse", err_timeout, 0);
        end
        @(negedge clk);
        check_eq("idle_prst", parser_reset, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("sel_hold", handler_sel, model_sel);
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        packet_complete = 1'b0;
        handler_done    = 1'b0;
        tx_done         = 1'b0;
        crc5invalid     = 1'b0;
        crc16invalid    = 1'b0;
        cmd_in          = 12'd0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_prst", parser_reset, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_start", handler_start, 0);
        check_eq("rst_sel", handler_sel, 0);
        check_eq("rst_txgo", tx_go, 0);
        check_eq("rst_errcrc", err_crc, 0);
        check_eq("rst_errto", err_timeout, 0);
        check_eq("rst_drops", drop_count, 0);
        reset       = 1'b0;
        model_drops = 0;
        model_sel   = 0;
        finish_rearm();
    endtask

    // hd/txd: cycle inside the wait state on which done is pulsed (> TIMEOUT means never).
    task automatic run_packet(input logic [11:0] cmd, input logic c5, input logic c16,
                              input int hd, input int txd, input bit stop_in_tx);
        bit drop;
        bit noreply;
        int sel;
        drop    = c5 || c16 || (cmd == 12'd0);
        sel     = drop ? model_sel : exp_sel(cmd);
        noreply = !drop && noreply_mask[sel];
        check_eq("pre_busy", busy, 0);
        cmd_in          = cmd;
        crc5invalid     = c5;
        crc16invalid    = c16;
        packet_complete = 1'b1;
        @(negedge clk);
        check_eq("check_busy", busy, 1);
        check_eq("check_start", handler_start, 0);
        @(negedge clk);
        if (drop) begin
            model_drops = sat_inc(model_drops);
            check_eq("drop_errcrc", err_crc, 1);
            check_eq("drop_start", handler_start, 0);
            finish_rearm();
            return;
        end
        model_sel = sel;
        check_eq("disp_start", handler_start, 1);
        check_eq("disp_sel", handler_sel, sel);
        check_eq("disp_errcrc", err_crc, 0);
        @(negedge clk);
        check_eq("wh_start_pulse", handler_start, 0);
        check_eq("wh_txgo", tx_go, 0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            handler_done = (k == hd);
            tx_done      = (k != hd) && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            handler_done = 1'b0;
            tx_done      = 1'b0;
            if (k == hd) break;
        end
        if (hd > TIMEOUT) begin
            model_drops = sat_inc(model_drops);
            check_eq("wh_timeout", err_timeout, 1);
            check_eq("wh_to_txgo", tx_go, 0);
            finish_rearm();
            return;
        end
        check_eq("wh_no_timeout", err_timeout, 0);
        if (noreply) begin
            check_eq("noreply_txgo", tx_go, 0);
            check_eq("noreply_prst", parser_reset, 1);
            finish_rearm();
            return;
        end
        check_eq("wtx_txgo", tx_go, 1);
        check_eq("wtx_prst", parser_reset, 0);
        if (stop_in_tx) return;
        for (int k = 1; k <= TIMEOUT; k++) begin
            tx_done      = (k == txd);
            handler_done = (k != txd) && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            tx_done      = 1'b0;
            handler_done = 1'b0;
            if (k == txd) break;
        end
        if (txd > TIMEOUT) begin
            model_drops = sat_inc(model_drops);
            check_eq("wtx_timeout", err_timeout, 1);
        end else begin
            check_eq("wtx_no_timeout", err_timeout, 0);
        end
        check_eq("wtx_exit_txgo", tx_go, 0);
        finish_rearm();
    endtask

    initial begin
        logic [11:0] cmd;
        logic        c5;
        logic        c16;
        int          hd;
        int          txd;

        do_reset();

        run_packet(12'h004, 1'b0, 1'b0, 3, 2, 1'b0);
        run_packet(12'h010, 1'b0, 1'b0, 2, 1, 1'b0);
        run_packet(12'h040, 1'b0, 1'b1, 1, 1, 1'b0);
        check_eq("drops_after_crc", drop_count, 1);
        run_packet(12'h000, 1'b0, 1'b0, 1, 1, 1'b0);
        check_eq("drops_after_zero", drop_count, 2);

        run_packet(12'h002, 1'b0, 1'b0, TIMEOUT + 1, 1, 1'b0);
        run_packet(12'h002, 1'b0, 1'b0, TIMEOUT, 3, 1'b0);
        run_packet(12'h004, 1'b0, 1'b0, 1, TIMEOUT + 1, 1'b0);
        run_packet(12'h004, 1'b0, 1'b0, 1, TIMEOUT, 1'b0);
        run_packet(12'h0A0, 1'b0, 1'b0, 2, 1, 1'b0);
        check_eq("multihot_sel", handler_sel, 5);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0:       cmd = 12'd0;
                1, 2:    cmd = 12'($urandom);
                default: cmd = 12'd1 << $urandom_range(0, 11);
            endcase
            c5  = ($urandom_range(0, 9) == 0);
            c16 = ($urandom_range(0, 9) == 0);
            hd  = ($urandom_range(0, 24) == 0) ? TIMEOUT + 1 : int'($urandom_range(1, 6));
            txd = ($urandom_range(0, 24) == 0) ? TIMEOUT + 1 : int'($urandom_range(1, 6));
            run_packet(cmd, c5, c16, hd, txd, 1'b0);
        end

        run_packet(12'h180, 1'b0, 1'b0, 2, 1, 1'b1);
        do_reset();

        for (int n = 0; n < 300; n++) begin
            c16 = 1'($urandom);
            run_packet(12'd1 << $urandom_range(0, 11), !c16, c16, 1, 1, 1'b0);
        end
        check_eq("drops_saturated", drop_count, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
